// File: rtl/iterative_multiplier_if.sv
// Request/response bundle between the decoder and the iterative multiplier.
interface iterative_multiplier_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  // Requester side (decoder / testbench)
  modport master (
    output start, mode, a, b,
    input  busy, done, result
  );

  // Responder side (multiplier)
  modport slave (
    input  start, mode, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/iterative_multiplier.sv
// Fixed-latency shift-add multiplier for MUL / UMULH / SMULH.
// Retires BITS_PER_CYCLE multiplier bits per BUSY cycle; done pulses for one
// cycle with the selected half of the 2*WIDTH product.
module iterative_multiplier #(
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input logic                   clk,
  input logic                   reset,
  iterative_multiplier_if.slave bus
);

  localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned Bpc  = BITS_PER_CYCLE;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [1:0]           mode_q, mode_d;
  logic                 sign_q, sign_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  // Upper half accumulates partial products; lower half starts as the
  // multiplier and is shifted out as product low bits shift in.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 smulh_req;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [Bpc-1:0]       digit;
  logic [WIDTH+Bpc-1:0] pp, sum;
  logic [2*WIDTH-1:0]   step;
  logic [WIDTH-1:0]     hi_neg;

  // Next-state, datapath step and output selection
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mode_d   = mode_q;
    sign_d   = sign_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    result_d = result_q;

    smulh_req = (bus.mode == 2'b10);
    // Magnitudes are unsigned WIDTH bits so |min_int| = 2^(WIDTH-1) fits.
    a_mag = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
    b_mag = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;

    digit = acc_q[Bpc-1:0];
    pp    = {{Bpc{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, digit};
    sum   = {{Bpc{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + pp;
    step  = {sum, acc_q[WIDTH-1:Bpc]};
    // High half of the two's-complement negation: carry into it only when
    // the low half is all zeros.
    hi_neg = ~step[2*WIDTH-1:WIDTH] + WIDTH'(step[WIDTH-1:0] == '0);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          sign_d  = smulh_req & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          mcand_d = smulh_req ? a_mag : bus.a;
          acc_d   = {{WIDTH{1'b0}}, (smulh_req ? b_mag : bus.b)};
          count_d = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        acc_d   = step;
        count_d = count_q + CntW'(1);
        if (count_q == CntW'(N - 1)) begin
          state_d = StDone;
          unique case (mode_q)
            2'b01:   result_d = step[2*WIDTH-1:WIDTH];
            2'b10:   result_d = sign_q ? hi_neg : step[2*WIDTH-1:WIDTH];
            default: result_d = step[WIDTH-1:0];
          endcase
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      mode_q   <= '0;
      sign_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      sign_q   <= sign_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
